// File: rtl/decade_pkg.sv
// Shared types and helpers for the cascaded BCD decade counter.
// Holds the controller state encoding and BCD digit constants.
package decade_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    // True when every one of the low n_digits digits of cnt reads 9.
    function automatic logic all_nines(
        input logic [MAX_DIGITS*BCD_W-1:0] cnt,
        input int unsigned                 n_digits
    );
        all_nines = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if ((i < n_digits) && (cnt[i*BCD_W +: BCD_W] != BCD_MAX)) begin
                all_nines = 1'b0;
            end
        end
    endfunction

endpackage

// File: rtl/bcd_stage.sv
// One BCD decade digit: counts 0..9 when enabled, carry is combinational
// so a whole chain of stages advances on a single clock edge.
module bcd_stage
    import decade_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             clr_sync,
    input  logic             en_in,
    output logic [BCD_W-1:0] q,
    output logic             carry_out
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (clr_sync) begin
            q <= '0;
        end else if (en_in) begin
            q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
        end
    end

    assign carry_out = en_in & (q == BCD_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Start/stop/lap event counter built from cascaded BCD decade stages.
// A prescaler produces count ticks that a small FSM gates into the digit chain.
module decade_chain_ctrl
    import decade_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      zero,
    input  logic                      lap,
    output logic [DIGITS*BCD_W-1:0]   count,
    output logic [DIGITS*BCD_W-1:0]   lap_value,
    output logic                      running,
    output logic                      overflow,
    output logic                      tick
);

    localparam int unsigned CW = DIGITS * BCD_W;
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            tick_q;
    logic            tick_d;
    logic [CW-1:0]   lap_q;
    logic [CW-1:0]   lap_d;
    logic [CW-1:0]   digits_w;
    logic            clr_c;
    logic            step_c;
    logic            full_c;
    logic [DIGITS:0] carry;
    logic            unused_carry;

    assign full_c = all_nines((MAX_DIGITS*BCD_W)'(digits_w), DIGITS);

    // Next-state, prescaler, lap capture and chain enable.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        lap_d   = lap_q;
        clr_c   = 1'b0;
        step_c  = 1'b0;

        if (zero) begin
            state_d = ST_IDLE;
            presc_d = '0;
            lap_d   = '0;
            clr_c   = 1'b1;
        end else begin
            if (lap) begin
                lap_d = digits_w;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRE_LAST) begin
                        presc_d = '0;
                        // A tick at all nines saturates instead of wrapping.
                        if (full_c) begin
                            state_d = ST_FULL;
                        end else begin
                            step_c = 1'b1;
                            tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            lap_q   <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            lap_q   <= lap_d;
        end
    end

    // Ripple enable through the chain; the top carry has no consumer.
    assign carry[0] = step_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_stage u_stage (
            .clock     (clock),
            .clear_n   (clear_n),
            .clr_sync  (clr_c),
            .en_in     (carry[g]),
            .q         (digits_w[g*BCD_W +: BCD_W]),
            .carry_out (carry[g+1])
        );
    end

    assign unused_carry = carry[DIGITS];

    assign count     = digits_w;
    assign lap_value = lap_q;
    assign tick      = tick_q;
    assign running   = (state_q == ST_RUN);
    assign overflow  = (state_q == ST_FULL);

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Bench for decade_chain_ctrl: an integer-valued stopwatch model checked every
// cycle against two instances (4 digits / prescale 10, 2 digits / prescale 2).
module tb_decade_chain_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_FULL  = 3;

    logic        clock;
    logic        clear_n;
    logic [1:0]  start_i;
    logic [1:0]  stop_i;
    logic [1:0]  zero_i;
    logic [1:0]  lap_i;

    logic [15:0] count0;
    logic [15:0] lapv0;
    logic        running0;
    logic        overflow0;
    logic        tick0;
    logic [7:0]  count1;
    logic [7:0]  lapv1;
    logic        running1;
    logic        overflow1;
    logic        tick1;

    int checks   = 0;
    int failures = 0;

    int m_n   [2];
    int m_ph  [2];
    int m_st  [2];
    int m_lap [2];
    bit m_tick[2];
    int pre   [2] = '{10, 2};
    int maxn  [2] = '{9999, 99};
    int ndig  [2] = '{4, 2};

    decade_chain_ctrl #(.DIGITS(4), .PRESCALE(10)) u_dut0 (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start_i[0]),
        .stop      (stop_i[0]),
        .zero      (zero_i[0]),
        .lap       (lap_i[0]),
        .count     (count0),
        .lap_value (lapv0),
        .running   (running0),
        .overflow  (overflow0),
        .tick      (tick0)
    );

    decade_chain_ctrl #(.DIGITS(2), .PRESCALE(2)) u_dut1 (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start_i[1]),
        .stop      (stop_i[1]),
        .zero      (zero_i[1]),
        .lap       (lap_i[1]),
        .count     (count1),
        .lap_value (lapv1),
        .running   (running1),
        .overflow  (overflow1),
        .tick      (tick1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Stopwatch model: elapsed ticks held as a plain integer.
    always @(posedge clock or negedge clear_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!clear_n) begin
                m_n[k] = 0; m_ph[k] = 0; m_st[k] = M_IDLE; m_lap[k] = 0; m_tick[k] = 1'b0;
            end else begin
                m_tick[k] = 1'b0;
                if (zero_i[k]) begin
                    m_n[k] = 0; m_ph[k] = 0; m_st[k] = M_IDLE; m_lap[k] = 0;
                end else begin
                    if (lap_i[k]) m_lap[k] = m_n[k];
                    if (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) begin
                        if (start_i[k] && !stop_i[k]) m_st[k] = M_RUN;
                    end else if (m_st[k] == M_RUN) begin
                        if (stop_i[k]) begin
                            m_st[k] = M_PAUSE;
                        end else if (m_ph[k] == pre[k] - 1) begin
                            m_ph[k] = 0;
                            if (m_n[k] == maxn[k]) m_st[k] = M_FULL;
                            else begin m_n[k]++; m_tick[k] = 1'b1; end
                        end else begin
                            m_ph[k]++;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            logic [15:0] c, l;
            logic        r, o, t;
            c = (k == 0) ? count0 : {8'h00, count1};
            l = (k == 0) ? lapv0  : {8'h00, lapv1};
            r = (k == 0) ? running0  : running1;
            o = (k == 0) ? overflow0 : overflow1;
            t = (k == 0) ? tick0     : tick1;
            chk($sformatf("dut%0d_count", k), 32'(c), to_bcd(m_n[k]));
            chk($sformatf("dut%0d_lap_value", k), 32'(l), to_bcd(m_lap[k]));
            chk($sformatf("dut%0d_running", k), 32'(r), 32'(m_st[k] == M_RUN));
            chk($sformatf("dut%0d_overflow", k), 32'(o), 32'(m_st[k] == M_FULL));
            chk($sformatf("dut%0d_tick", k), 32'(t), 32'(m_tick[k]));
            for (int d = 0; d < ndig[k]; d++) begin
                chk($sformatf("dut%0d_bcd_digit%0d", k, d), 32'(c[d*4 +: 4] <= 4'd9), 32'd1);
            end
        end
    end

    task automatic wait_ticks(input int n);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < n * 10 + 20) begin
            @(negedge clock);
            cyc++;
            if (tick0) seen++;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL wait_ticks seen=%0d required=%0d", seen, n);
        end
    endtask

    initial begin
        int n;
        clear_n = 1'b0;
        start_i = '0; stop_i = '0; zero_i = '0; lap_i = '0;
        repeat (3) @(negedge clock);
        chk("rst_count", 32'(count0), 32'h0);
        chk("rst_lap_value", 32'(lapv0), 32'h0);
        chk("rst_running", 32'(running0), 32'h0);
        chk("rst_overflow", 32'(overflow0), 32'h0);
        chk("rst_tick", 32'(tick0), 32'h0);
        #1 clear_n = 1'b1;

        // Start and first-tick latency.
        @(negedge clock); #1 start_i[0] = 1'b1;
        @(negedge clock); #1 start_i[0] = 1'b0;
        chk("run_entry", 32'(running0), 32'h1);
        n = 0;
        do begin @(negedge clock); n++; end while (!tick0 && n < 50);
        chk("first_tick_latency", 32'(n), 32'd10);
        wait_ticks(34);
        chk("count_35", 32'(count0), 32'h0035);
        chk("running_35", 32'(running0), 32'h1);

        // Pause with prescaler at 6, hold 50 cycles, resume.
        repeat (6) @(negedge clock);
        #1 stop_i[0] = 1'b1;
        repeat (50) @(negedge clock);
        chk("pause_count_held", 32'(count0), 32'h0035);
        chk("pause_not_running", 32'(running0), 32'h0);
        #1 stop_i[0] = 1'b0; start_i[0] = 1'b1;
        @(negedge clock); #1 start_i[0] = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (!tick0 && n < 50);
        chk("resume_tick_latency", 32'(n), 32'd4);
        chk("count_36", 32'(count0), 32'h0036);

        // Lap captured on a tick cycle.
        wait_ticks(5);
        chk("count_41", 32'(count0), 32'h0041);
        repeat (9) @(negedge clock);
        #1 lap_i[0] = 1'b1;
        @(negedge clock); #1 lap_i[0] = 1'b0;
        chk("lap_tick", 32'(tick0), 32'h1);
        chk("lap_count_42", 32'(count0), 32'h0042);
        chk("lap_value_41", 32'(lapv0), 32'h0041);
        wait_ticks(1);
        chk("count_43", 32'(count0), 32'h0043);

        // Cascades across several digits.
        wait_ticks(56);
        chk("count_99", 32'(count0), 32'h0099);
        wait_ticks(1);
        chk("count_100", 32'(count0), 32'h0100);
        wait_ticks(899);
        chk("count_999", 32'(count0), 32'h0999);
        wait_ticks(1);
        chk("count_1000", 32'(count0), 32'h1000);

        // zero beats start.
        #1 zero_i[0] = 1'b1; start_i[0] = 1'b1;
        @(negedge clock); #1 zero_i[0] = 1'b0; start_i[0] = 1'b0;
        chk("zero_start_count", 32'(count0), 32'h0);
        chk("zero_start_lap", 32'(lapv0), 32'h0);
        chk("zero_start_running", 32'(running0), 32'h0);
        @(negedge clock);
        chk("zero_start_stays_idle", 32'(running0), 32'h0);

        // Asynchronous reset mid-count.
        #1 start_i[0] = 1'b1;
        @(negedge clock); #1 start_i[0] = 1'b0;
        wait_ticks(100);
        #1 lap_i[0] = 1'b1;
        @(negedge clock); #1 lap_i[0] = 1'b0;
        wait_ticks(412);
        chk("count_512", 32'(count0), 32'h0512);
        #2 clear_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count0), 32'h0);
        chk("async_rst_lap", 32'(lapv0), 32'h0);
        chk("async_rst_running", 32'(running0), 32'h0);
        chk("async_rst_tick", 32'(tick0), 32'h0);
        @(negedge clock); #1 clear_n = 1'b1;

        // Overflow on the two-digit instance.
        @(negedge clock); #1 start_i[1] = 1'b1;
        @(negedge clock); #1 start_i[1] = 1'b0;
        n = 0;
        while (!overflow1 && n < 400) begin @(negedge clock); n++; end
        chk("ovf_reached", 32'(overflow1), 32'h1);
        chk("ovf_count", 32'(count1), 32'h99);
        chk("ovf_tick", 32'(tick1), 32'h0);
        chk("ovf_running", 32'(running1), 32'h0);
        #1 start_i[1] = 1'b1; stop_i[1] = 1'b1;
        repeat (3) @(negedge clock);
        chk("ovf_ignores_cmds", 32'(overflow1), 32'h1);
        chk("ovf_count_held", 32'(count1), 32'h99);
        #1 start_i[1] = 1'b0; stop_i[1] = 1'b0; zero_i[1] = 1'b1;
        @(negedge clock); #1 zero_i[1] = 1'b0;
        chk("ovf_zero_count", 32'(count1), 32'h00);
        chk("ovf_zero_overflow", 32'(overflow1), 32'h0);
        chk("ovf_zero_running", 32'(running1), 32'h0);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decade_chain_ctrl.md
Name: decade_chain_ctrl

Overview:
Synchronous controller that sequences a chain of cascaded BCD decade stages as a start/stop/lap event counter (stopwatch style). A prescaler generates count ticks, and a small FSM gates them. Carries ripple combinationally between digits within one clock, so all digits update on the same edge. Overflow, lap capture and zeroing are handled centrally. It replaces per-digit clear gating in higher-level counting designs.

Parameters:
DIGITS, 4, number of cascaded BCD decade stages (1..8)
PRESCALE, 10, clock cycles per count tick (2..65535)

Ports:
clock  in  1  system clock, all state on rising edge
clear_n  in  1  asynchronous active-low reset
start  in  1  level, begin/resume counting
stop  in  1  level, pause counting
zero  in  1  synchronous clear of digits, lap and prescaler
lap  in  1  capture current digits into lap_value
count  out  4*DIGITS  live BCD digits, digit 0 in bits [3:0]
lap_value  out  4*DIGITS  last captured digits
running  out  1  high in RUN
overflow  out  1  high in FULL
tick  out  1  one-cycle pulse on each digit-0 increment

Behaviour:
- Reset (clear_n=0, asynchronous): state=IDLE, count=0, lap_value=0, prescaler=0, running=0, overflow=0, tick=0.
- States: IDLE, RUN, PAUSE, FULL. Encoding is 2 bits, from the package.
- Command priority per cycle: zero > stop > start. lap is independent of the commands.
- IDLE: start -> RUN. Digits are 0.
- RUN: stop -> PAUSE, and the prescaler holds its value. Otherwise the prescaler increments.
  - When the prescaler reaches PRESCALE-1, it wraps to 0 and tick=1 on the next cycle, registered together with the digit update.
- Digit update on a tick:
  - Digit 0 increments.
  - Digit i increments only when all lower digits are 9.
  - A digit at 9 that increments wraps to 0.
  - All digits update on the same clock edge. There is no intermediate ripple state.
- Terminal count: a tick while every digit is 9 -> digits stay at all 9s, state=FULL, overflow=1, tick=0 for that cycle.
- PAUSE: start (with stop low) -> RUN. The prescaler resumes from its held value, so partial tick time is preserved. Digits are held.
- FULL: only zero exits, to IDLE. start and stop are ignored.
- zero, in any state: next cycle count=0, lap_value=0, prescaler=0, state=IDLE, overflow=0.
  - If start is also high, the state is still IDLE. start must be re-asserted on a later cycle.
- lap, when zero is low: lap_value <= the count value visible in the same cycle, i.e. the pre-update value. This holds even on a tick cycle.
  - Capture is valid in every state except that zero wins.
- start and stop both high: stop wins (RUN -> PAUSE, PAUSE stays).
- The digit width rule is a 4-bit BCD value per digit. Values 10..15 are unreachable. The bench asserts this.
- running = (state==RUN). Outputs are registered or decoded from registered state only, with no input-to-output combinational path.
- Reset mid-count clears everything asynchronously. Counting resumes only after clear_n is deasserted and start is asserted.

Decomposition:
- Package decade_pkg: the state enum for IDLE/RUN/PAUSE/FULL, BCD_MAX=4'd9, BCD_W=4, and a function all_nines(count).
- Sub-module bcd_stage: one decade digit.
  - Inputs: clock, clear_n, clr_sync, en_in.
  - Outputs: q[3:0], carry_out = en_in & (q==9).
  - It is instantiated DIGITS times in a generate loop, with carry_out feeding the next en_in.
- The FSM, prescaler and lap register stay in decade_chain_ctrl.

Test Plan:
- Reset then start with PRESCALE=10: the first tick arrives 10 cycles after RUN entry. After 35 ticks, count=0x0035 and running=1.
- Cascade: run to count 0x0099, then one more tick -> 0x0100 on a single edge. After further ticks, 0x0999 -> 0x1000. No intermediate values appear on any cycle.
- Pause preservation: stop at prescaler=6, hold 50 cycles, then start. The next tick arrives 4 cycles later and count is unchanged during the pause.
- Overflow with DIGITS=2: run past 0x99 -> count stays 0x99, overflow=1, state FULL. start and stop are ignored. zero -> count=0x00, overflow=0, IDLE.
- Lap on a tick cycle: lap asserted in the cycle count=0x0041 -> 0x0042. lap_value=0x0041, and count continues to 0x0043 normally.
- Priority and reset: zero+start together in RUN -> IDLE with count=0. clear_n low mid-count at 0x0512 -> all outputs 0 immediately, without waiting for a clock edge.
